vc_credit_tracker: RTL and testbench

// - Registered per-output-port VC state and credit tracker; successor to the combinational availability updater.
// - Tracks, per downstream input VC: busy/free state and a buffer-slot credit count. Serves VC allocation,
//   SA flit departures, and downstream credit/VC-release returns, several ports per cycle.
// - Sits between VC allocator / switch allocator and the output links of the router.

---
 rtl/vc_router_pkg.sv | 11 +
 rtl/vc_credit_port.sv | 95 +++++++++
 rtl/vc_credit_tracker.sv | 63 ++++++
 tb/tb_vc_credit_tracker.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vc_router_pkg.sv
// Shared sizing and types for the per-port VC state / credit tracker.
package vc_router_pkg;
  localparam int NUM_PORTS = 5;
  localparam int NUM_VCS   = 4;
  localparam int BUF_DEPTH = 4;
  localparam int VC_W      = $clog2(NUM_VCS);
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

  typedef logic [VC_W-1:0]  vc_id_t;
  typedef logic [CNT_W-1:0] credit_cnt_t;
endpackage

// File: rtl/vc_credit_port.sv
// One output port: VC busy/free bitmap, per-VC credit counters and highest-index free-VC picker.
// CREDIT_BYPASS_EN: returned credits / released VCs are visible combinationally in the same cycle.
module vc_credit_port
  import vc_router_pkg::*;
#(
  parameter int NUM_VCS   = vc_router_pkg::NUM_VCS,
  parameter int BUF_DEPTH = vc_router_pkg::BUF_DEPTH,
  localparam int VC_W     = $clog2(NUM_VCS),
  localparam int CNT_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_alloc_req,
  output logic                            o_alloc_gnt,
  output logic [VC_W-1:0]                 o_alloc_vc,
  input  logic                            i_flit_sent,
  input  logic [VC_W-1:0]                 i_flit_vc,
  input  logic                            i_credit_ret,
  input  logic [VC_W-1:0]                 i_credit_vc,
  input  logic                            i_vc_release,
  output logic [NUM_VCS-1:0]              o_vc_free,
  output logic [NUM_VCS-1:0]              o_credit_avail,
  output logic [NUM_VCS-1:0][CNT_W-1:0]   o_credit_count,
  output logic                            o_underflow,
  output logic                            o_overflow
);
  logic [NUM_VCS-1:0]            r_free;
  logic [NUM_VCS-1:0][CNT_W-1:0] r_cnt;

  logic [NUM_VCS-1:0] w_dec, w_inc, w_rel, w_zero, w_full;
  logic [NUM_VCS-1:0] w_elig, w_avail_byp, w_take;
  logic [VC_W-1:0]    w_pick_vc;
  logic               w_any;

  always_comb begin
    w_dec = '0;
    w_inc = '0;
    w_rel = '0;
    w_zero = '0;
    w_full = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      w_dec[v]  = i_flit_sent  && (i_flit_vc   == VC_W'(v));
      w_inc[v]  = i_credit_ret && (i_credit_vc == VC_W'(v));
      w_rel[v]  = w_inc[v] && i_vc_release;
      w_zero[v] = (r_cnt[v] == '0);
      w_full[v] = (r_cnt[v] == CNT_W'(BUF_DEPTH));
    end
`ifdef CREDIT_BYPASS_EN
    w_elig      = r_free | w_rel;
    w_avail_byp = w_inc;
`else
    w_elig      = r_free;
    w_avail_byp = '0;
`endif
  end

  // ascending scan: the last hit wins, giving the highest free index
  always_comb begin
    w_pick_vc = '0;
    for (int v = 0; v < NUM_VCS; v++)
      if (w_elig[v]) w_pick_vc = VC_W'(v);
  end

  assign w_any       = |w_elig;
  assign o_alloc_gnt = i_alloc_req && w_any && !reset;
  assign o_alloc_vc  = reset ? '0 : w_pick_vc;

  always_comb begin
    w_take = '0;
    if (o_alloc_gnt) w_take[w_pick_vc] = 1'b1;
  end

  // a matched dec+inc cancels, so neither error fires in that case
  assign o_underflow = |(w_dec & ~w_inc & w_zero);
  assign o_overflow  = |(w_inc & ~w_dec & w_full);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_free <= '1;
      for (int v = 0; v < NUM_VCS; v++) r_cnt[v] <= CNT_W'(BUF_DEPTH);
    end else begin
      r_free <= (r_free | w_rel) & ~w_take;
      for (int v = 0; v < NUM_VCS; v++) begin
        if (w_dec[v] && !w_inc[v] && !w_zero[v])
          r_cnt[v] <= r_cnt[v] - CNT_W'(1);
        else if (w_inc[v] && !w_dec[v] && !w_full[v])
          r_cnt[v] <= r_cnt[v] + CNT_W'(1);
      end
    end
  end

  assign o_vc_free      = r_free;
  assign o_credit_count = r_cnt;
  assign o_credit_avail = ~w_zero | w_avail_byp;
endmodule

// File: rtl/vc_credit_tracker.sv
// Registered per-output-port VC state and credit tracker; one vc_credit_port per output port.
// Optional same-cycle credit/release bypass lives in vc_credit_port under CREDIT_BYPASS_EN.
module vc_credit_tracker
  import vc_router_pkg::*;
#(
  parameter int NUM_PORTS = vc_router_pkg::NUM_PORTS,
  parameter int NUM_VCS   = vc_router_pkg::NUM_VCS,
  parameter int BUF_DEPTH = vc_router_pkg::BUF_DEPTH,
  localparam int VC_W     = $clog2(NUM_VCS),
  localparam int CNT_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PORTS-1:0]                alloc_req,
  output logic [NUM_PORTS-1:0]                alloc_gnt,
  output logic [NUM_PORTS*VC_W-1:0]           alloc_vc,
  input  logic [NUM_PORTS-1:0]                flit_sent,
  input  logic [NUM_PORTS*VC_W-1:0]           flit_vc,
  input  logic [NUM_PORTS-1:0]                credit_ret,
  input  logic [NUM_PORTS*VC_W-1:0]           credit_vc,
  input  logic [NUM_PORTS-1:0]                vc_release,
  output logic [NUM_PORTS*NUM_VCS-1:0]        vc_free,
  output logic [NUM_PORTS*NUM_VCS-1:0]        credit_avail,
  output logic [NUM_PORTS*NUM_VCS*CNT_W-1:0]  credit_count,
  output logic                                err_underflow,
  output logic                                err_overflow
);
  logic [NUM_PORTS-1:0] w_uf, w_of;
  logic                 r_err_uf, r_err_of;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    vc_credit_port #(.NUM_VCS(NUM_VCS), .BUF_DEPTH(BUF_DEPTH)) u_port (
      .clk            (clk),
      .reset          (reset),
      .i_alloc_req    (alloc_req[p]),
      .o_alloc_gnt    (alloc_gnt[p]),
      .o_alloc_vc     (alloc_vc[p*VC_W +: VC_W]),
      .i_flit_sent    (flit_sent[p]),
      .i_flit_vc      (flit_vc[p*VC_W +: VC_W]),
      .i_credit_ret   (credit_ret[p]),
      .i_credit_vc    (credit_vc[p*VC_W +: VC_W]),
      .i_vc_release   (vc_release[p]),
      .o_vc_free      (vc_free[p*NUM_VCS +: NUM_VCS]),
      .o_credit_avail (credit_avail[p*NUM_VCS +: NUM_VCS]),
      .o_credit_count (credit_count[p*NUM_VCS*CNT_W +: NUM_VCS*CNT_W]),
      .o_underflow    (w_uf[p]),
      .o_overflow     (w_of[p])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_uf <= 1'b0;
      r_err_of <= 1'b0;
    end else begin
      r_err_uf <= r_err_uf | (|w_uf);
      r_err_of <= r_err_of | (|w_of);
    end
  end

  assign err_underflow = r_err_uf;
  assign err_overflow  = r_err_of;
endmodule

// File: tb/tb_vc_credit_tracker.sv
// Directed + random bench for vc_credit_tracker against an array-based reference model.
module tb_vc_credit_tracker;
  localparam int NP = 5, NV = 4, BD = 4, VW = 2, CW = 3;
`ifdef CREDIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [NP-1:0]       alloc_req, alloc_gnt, flit_sent, credit_ret, vc_release;
  logic [NP*VW-1:0]    alloc_vc, flit_vc, credit_vc;
  logic [NP*NV-1:0]    vc_free, credit_avail;
  logic [NP*NV*CW-1:0] credit_count;
  logic                err_underflow, err_overflow;

  int checks = 0, failures = 0;
  bit mfree [NP][NV];
  int mcnt  [NP][NV];
  bit muf, mof;

  vc_credit_tracker dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_vc(alloc_vc),
    .flit_sent(flit_sent), .flit_vc(flit_vc), .credit_ret(credit_ret), .credit_vc(credit_vc),
    .vc_release(vc_release), .vc_free(vc_free), .credit_avail(credit_avail),
    .credit_count(credit_count), .err_underflow(err_underflow), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fld(input logic [NP*VW-1:0] f, input int p);
    return int'(f[p*VW +: VW]);
  endfunction

  function automatic bit eligible(input int p, input int v);
    return mfree[p][v] || (BYP && vc_release[p] && credit_ret[p] && fld(credit_vc, p) == v);
  endfunction

  function automatic int pick(input int p);
    for (int v = NV - 1; v >= 0; v--) if (eligible(p, v)) return v;
    return -1;
  endfunction

  function automatic logic [2:0] cnt_of(input int p, input int v);
    return credit_count[(p*NV + v)*CW +: CW];
  endfunction

  task automatic idle();
    alloc_req = '0; flit_sent = '0; credit_ret = '0; vc_release = '0;
    flit_vc = '0; credit_vc = '0;
  endtask

  // combinational outputs for the current inputs against the model
  task automatic settle();
    logic [NP-1:0]    eg;
    logic [NP*VW-1:0] ev;
    logic [NP*NV-1:0] ea;
    #1;
    eg = '0; ev = '0; ea = '0;
    for (int p = 0; p < NP; p++) begin
      int k = pick(p);
      eg[p] = !reset && alloc_req[p] && (k >= 0);
      ev[p*VW +: VW] = (reset || k < 0) ? 2'd0 : 2'(k);
      for (int v = 0; v < NV; v++)
        ea[p*NV + v] = (mcnt[p][v] != 0) || (BYP && credit_ret[p] && fld(credit_vc, p) == v);
    end
    chk("alloc_gnt", 64'(alloc_gnt), 64'(eg));
    chk("alloc_vc", 64'(alloc_vc), 64'(ev));
    chk("credit_avail", 64'(credit_avail), 64'(ea));
  endtask

  // clock edge: advance the model, then compare registered state
  task automatic clock();
    int k [NP];
    logic [NP*NV-1:0]    ef;
    logic [NP*NV*CW-1:0] ec;
    for (int p = 0; p < NP; p++) k[p] = alloc_req[p] ? pick(p) : -1;
    @(posedge clk);
    if (reset) begin
      for (int p = 0; p < NP; p++)
        for (int v = 0; v < NV; v++) begin mfree[p][v] = 1'b1; mcnt[p][v] = BD; end
      muf = 1'b0; mof = 1'b0;
    end else begin
      for (int p = 0; p < NP; p++)
        for (int v = 0; v < NV; v++) begin
          bit d = flit_sent[p] && fld(flit_vc, p) == v;
          bit i = credit_ret[p] && fld(credit_vc, p) == v;
          if (d && !i) begin
            if (mcnt[p][v] == 0) muf = 1'b1; else mcnt[p][v]--;
          end else if (i && !d) begin
            if (mcnt[p][v] == BD) mof = 1'b1; else mcnt[p][v]++;
          end
          if (i && vc_release[p]) mfree[p][v] = 1'b1;
          if (k[p] == v) mfree[p][v] = 1'b0;
        end
    end
    #1;
    for (int p = 0; p < NP; p++)
      for (int v = 0; v < NV; v++) begin
        ef[p*NV + v] = mfree[p][v];
        ec[(p*NV + v)*CW +: CW] = 3'(mcnt[p][v]);
      end
    chk("vc_free", 64'(vc_free), 64'(ef));
    chk("credit_count", 64'(credit_count), 64'(ec));
    chk("err_underflow", 64'(err_underflow), 64'(muf));
    chk("err_overflow", 64'(err_overflow), 64'(mof));
  endtask

  initial begin
    logic [NP*NV*CW-1:0] all4;
    all4 = {NP*NV{3'b100}};
    idle();
    reset = 1'b1;
    settle(); clock(); clock();
    reset = 1'b0;
    settle(); clock();
    chk("rst_free", 64'(vc_free), 64'hF_FFFF);
    chk("rst_count", 64'(credit_count), 64'(all4));
    chk("rst_avail", 64'(credit_avail), 64'hF_FFFF);
    chk("rst_errs", 64'({err_underflow, err_overflow}), 64'd0);

    // port 2 drains all four VCs, highest first
    for (int i = 0; i < 5; i++) begin
      alloc_req = 5'b00100;
      settle();
      chk("p2_gnt", 64'(alloc_gnt[2]), (i < 4) ? 64'd1 : 64'd0);
      chk("p2_vc", 64'(alloc_vc[5:4]), (i < 4) ? 64'(3 - i) : 64'd0);
      clock();
    end
    idle(); settle();
    chk("p2_free", 64'(vc_free[11:8]), 64'd0);

    // port 0 VC1 runs out of credits, fifth send underflows
    for (int i = 0; i < 5; i++) begin
      flit_sent = 5'b00001; flit_vc = 10'h001;
      settle(); clock();
      chk("p0v1_cnt", 64'(cnt_of(0, 1)), (i < 4) ? 64'(3 - i) : 64'd0);
    end
    idle(); settle();
    chk("p0v1_avail", 64'(credit_avail[1]), 64'd0);
    chk("underflow", 64'(err_underflow), 64'd1);

    // port 1 VC2: send+return cancel, then return at full overflows
    flit_sent = 5'b00010; flit_vc = 10'h008; credit_ret = 5'b00010; credit_vc = 10'h008;
    settle(); clock();
    chk("p1v2_cnt", 64'(cnt_of(1, 2)), 64'd4);
    chk("no_overflow", 64'(err_overflow), 64'd0);
    flit_sent = '0;
    settle(); clock();
    chk("overflow", 64'(err_overflow), 64'd1);
    chk("p1v2_held", 64'(cnt_of(1, 2)), 64'd4);

    // port 3: fill, then release VC0 alongside a request
    idle();
    for (int i = 0; i < 4; i++) begin alloc_req = 5'b01000; settle(); clock(); end
    alloc_req = 5'b01000; credit_ret = 5'b01000; vc_release = 5'b01000; credit_vc = '0;
    settle();
    chk("rel_same_gnt", 64'(alloc_gnt[3]), 64'(BYP));
    clock();
    idle(); alloc_req = 5'b01000;
    settle();
    chk("rel_next_gnt", 64'(alloc_gnt[3]), BYP ? 64'd0 : 64'd1);
    if (!BYP) chk("rel_next_vc", 64'(alloc_vc[7:6]), 64'd0);
    clock();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      alloc_req  = NP'($urandom);
      flit_sent  = NP'($urandom);
      credit_ret = NP'($urandom);
      vc_release = NP'($urandom) & credit_ret;
      flit_vc    = (NP*VW)'($urandom);
      credit_vc  = (NP*VW)'($urandom);
      settle(); clock();
    end

    // reset mid-traffic overrides the same-cycle events
    flit_sent = '1; credit_ret = '1; alloc_req = '1; vc_release = '1;
    reset = 1'b1;
    settle(); clock();
    reset = 1'b0; idle();
    settle();
    chk("mid_rst_free", 64'(vc_free), 64'hF_FFFF);
    chk("mid_rst_count", 64'(credit_count), 64'(all4));
    chk("mid_rst_errs", 64'({err_underflow, err_overflow}), 64'd0);
    clock();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
